minmax_window_tracker: RTL
==========================

Name: minmax_window_tracker

Overview:
Parametrised successor to the team's min/max stream controller. It combines FSM and datapath in one block. It tracks the running minimum and maximum of a windowed sample stream using a valid/ready input handshake. Unsigned or signed comparison is selectable. After WINDOW samples it presents the result through a valid/ready output handshake. It sits between a sample producer (ADC/FIFO front end) and a consumer that reads per-window statistics.

Parameters:
WIDTH, 8, sample and min/max width in bits (>=2)
WINDOW, 16, samples per window (>=1)
SIGNED, 0, 0 = unsigned compare, 1 = two's-complement compare
CNT_W, $clog2(WINDOW+1), derived width of the sample counter; not overridden

Ports:
clk  in  1  single clock, all state updates on rising edge
rst  in  1  synchronous, active-low reset (0 = reset)
start  in  1  begin a new window; honoured only in IDLE, or in DONE together with res_ready
abort  in  1  discard the window in progress; return to IDLE
in_valid  in  1  sample available
in_data  in  WIDTH  sample value
in_ready  out  1  block accepts a sample; a handshake occurs when in_valid & in_ready
res_valid  out  1  min_out/max_out/count_out hold a completed window
res_ready  in  1  consumer takes the result
min_out  out  WIDTH  registered running minimum
max_out  out  WIDTH  registered running maximum
count_out  out  CNT_W  samples accepted in the current window
busy  out  1  high in FIRST or TRACK

Behaviour:
- Reset (rst=0 at a clock edge): state=IDLE; min_out, max_out and count_out are 0; res_valid, in_ready and busy are 0. Reset has priority over all other inputs in every state, including mid-window.
- States use a 2-bit encoding: IDLE, FIRST, TRACK, DONE. in_ready, res_valid and busy are Moore outputs decoded from state.
- IDLE: in_ready=0. On start, go to FIRST and clear count_out to 0. min_out/max_out keep the previous window's values.
- FIRST: in_ready=1, busy=1. On a handshake, min_out=max_out=in_data and count_out=1. Then go to DONE if WINDOW==1, otherwise to TRACK. With no handshake, stay in FIRST.
- TRACK: in_ready=1, busy=1. On a handshake:
  - If in_data < min_out, min_out=in_data.
  - If in_data > max_out, max_out=in_data.
  - Both updates are evaluated independently; there is no priority. Equal values change nothing.
  - count_out increments.
  - If count_out==WINDOW-1 before the increment, go to DONE.
- Idle cycles with in_valid=0 change nothing.
- Comparison: with SIGNED=0, unsigned magnitude; with SIGNED=1, two's-complement (0x80 < 0x7F for WIDTH=8). No width extension is needed because compare and storage share WIDTH.
- DONE: res_valid=1, in_ready=0, and outputs are held stable. On res_ready:
  - with start also high, go to FIRST and clear count_out (back-to-back windows, no IDLE bubble);
  - otherwise go to IDLE.
- abort in FIRST or TRACK: go to IDLE next cycle and clear count_out. Any handshake in that same cycle is discarded. abort is ignored in IDLE and DONE.
- start outside IDLE, and outside DONE with res_ready, is ignored; there is no queuing.
- Latency: res_valid rises on the clock edge that captures the WINDOW-th accepted sample, so it is visible in the cycle after that handshake.
- Throughput: one sample per cycle in FIRST/TRACK.

Decomposition:
- Package minmax_pkg holds the state localparams (IDLE=2'b00, FIRST=2'b01, TRACK=2'b10, DONE=2'b11).
- Sub-module minmax_datapath holds the min/max/count registers and signed/unsigned comparators. It exports lt_min, gt_max and cnt_last, and takes load_first, update, clr_cnt and inc_cnt.
- Top level contains the FSM only.

Test Plan:
1. WIDTH=8, WINDOW=4, SIGNED=0. start, then samples 5,9,2,7 on consecutive cycles -> min_out=2, max_out=9, count_out=4; res_valid=1 in the cycle after the 4th handshake.
2. SIGNED=1, WINDOW=4. Samples 0xFE,0x03,0x80,0x7F -> min_out=0x80, max_out=0x7F. Also all-equal samples 0x33 x4 -> min_out=max_out=0x33.
3. Gaps and back-pressure. in_valid toggles 1,0,0,1,... -> count_out advances only on handshakes. In DONE with res_ready=0 for 10 cycles -> in_ready=0 and outputs stable. Then res_ready=1 with start=1 -> next cycle FIRST, count_out=0, in_ready=1.
4. Reset mid-window. rst=0 during TRACK after 2 samples -> next cycle IDLE; min_out, max_out and count_out are 0; in_ready=0 and res_valid=0.
5. abort during TRACK after 3 of 4 samples, with in_valid=1 that cycle -> next cycle IDLE, count_out=0, res_valid never asserted, sample discarded.
6. WINDOW=1. start, then sample 0x42 -> DONE next cycle with min_out=max_out=0x42 and count_out=1; no TRACK cycle.

Source files
------------

// File: rtl/minmax_pkg.sv
// Shared state encoding for the windowed min/max tracker.
// Kept in a package so the FSM and any future consumers agree on it.
package minmax_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'b00;
    localparam state_t FIRST = 2'b01;
    localparam state_t TRACK = 2'b10;
    localparam state_t DONE  = 2'b11;

endpackage

// File: rtl/minmax_datapath.sv
// Min/max/count registers and the compare logic for one window.
// Signedness is fixed at elaboration; compare and storage share WIDTH.
module minmax_datapath
    import minmax_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int WINDOW = 16,
    parameter int SIGNED = 0,
    parameter int CNT_W  = $clog2(WINDOW + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             load_first,
    input  logic             update,
    input  logic             clr_cnt,
    input  logic             inc_cnt,
    output logic             lt_min,
    output logic             gt_max,
    output logic             cnt_last,
    output logic [WIDTH-1:0] min_out,
    output logic [WIDTH-1:0] max_out,
    output logic [CNT_W-1:0] count_out
);

    generate
        if (SIGNED != 0) begin : g_signed
            assign lt_min = $signed(in_data) < $signed(min_out);
            assign gt_max = $signed(in_data) > $signed(max_out);
        end else begin : g_unsigned
            assign lt_min = in_data < min_out;
            assign gt_max = in_data > max_out;
        end
    endgenerate

    assign cnt_last = (count_out == CNT_W'(WINDOW - 1));

    // min and max update independently; equal samples leave both alone
    always_ff @(posedge clk) begin
        if (!rst) begin
            min_out <= '0;
            max_out <= '0;
        end else if (load_first) begin
            min_out <= in_data;
            max_out <= in_data;
        end else if (update) begin
            if (lt_min) min_out <= in_data;
            if (gt_max) max_out <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_out <= '0;
        end else if (clr_cnt) begin
            count_out <= '0;
        end else if (load_first) begin
            count_out <= CNT_W'(1);
        end else if (inc_cnt) begin
            count_out <= count_out + CNT_W'(1);
        end
    end

endmodule

// File: rtl/minmax_window_tracker.sv
// Windowed running min/max tracker: FSM around minmax_datapath.
// Samples enter on in_valid/in_ready, results leave on res_valid/res_ready.
module minmax_window_tracker
    import minmax_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int WINDOW = 16,
    parameter int SIGNED = 0,
    parameter int CNT_W  = $clog2(WINDOW + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] min_out,
    output logic [WIDTH-1:0] max_out,
    output logic [CNT_W-1:0] count_out,
    output logic             busy
);

    state_t state;
    state_t state_nxt;

    logic st_idle;
    logic st_first;
    logic st_track;
    logic st_done;
    logic hs;
    logic take;
    logic load_first;
    logic update;
    logic clr_cnt;
    logic inc_cnt;
    logic lt_min;
    logic gt_max;
    logic cnt_last;

    assign st_idle  = (state == IDLE);
    assign st_first = (state == FIRST);
    assign st_track = (state == TRACK);
    assign st_done  = (state == DONE);

    assign in_ready  = st_first | st_track;
    assign busy      = st_first | st_track;
    assign res_valid = st_done;

    // abort wins over a same-cycle handshake
    assign hs         = in_valid & in_ready;
    assign take       = hs & ~abort;
    assign load_first = st_first & take;
    assign update     = st_track & take;
    assign inc_cnt    = update;
    assign clr_cnt    = (st_idle & start)
                      | (st_done & res_ready & start)
                      | (busy & abort);

    always_comb begin
        state_nxt = state;
        unique case (1'b1)
            st_idle: begin
                if (start) state_nxt = FIRST;
            end
            st_first: begin
                if (abort)
                    state_nxt = IDLE;
                else if (hs)
                    state_nxt = (WINDOW == 1) ? DONE : TRACK;
            end
            st_track: begin
                if (abort)
                    state_nxt = IDLE;
                else if (hs && cnt_last)
                    state_nxt = DONE;
            end
            st_done: begin
                if (res_ready)
                    state_nxt = start ? FIRST : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    minmax_datapath #(
        .WIDTH  (WIDTH),
        .WINDOW (WINDOW),
        .SIGNED (SIGNED),
        .CNT_W  (CNT_W)
    ) u_dp (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .load_first (load_first),
        .update     (update),
        .clr_cnt    (clr_cnt),
        .inc_cnt    (inc_cnt),
        .lt_min     (lt_min),
        .gt_max     (gt_max),
        .cnt_last   (cnt_last),
        .min_out    (min_out),
        .max_out    (max_out),
        .count_out  (count_out)
    );

endmodule
